video_timing_gen: RTL and testbench



---
 rtl/video_timing_gen.sv | 144 ++++++++++++++
 tb/tb_video_timing_gen.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator with registered, mutually aligned outputs
//
// Purpose:
//   Free-running horizontal/vertical position counters with an explicit
//   SYNC/BPORCH/ACTIVE/FPORCH state register per axis. The counters and the
//   axis states are decoded into the active-video enable, the sync pulses and
//   the line/frame start strobes. Every output is loaded in the same register
//   stage, so the whole tuple always describes one raster position.
//
// Ports:
//   clk          pixel clock, the only clock
//   rst          asynchronous active-high reset
//   en           pixel-clock enable; nothing advances while low
//   x, y         raw position presented this cycle (0..H_TOTAL-1, 0..V_TOTAL-1)
//   vde          high while (x, y) lies inside the active region
//   hsync        HS_POL during the horizontal sync interval, ~HS_POL otherwise
//   vsync        VS_POL during the vertical sync lines, ~VS_POL otherwise
//   line_start   one-cycle strobe on each new presentation of x == 0
//   frame_start  one-cycle strobe on each new presentation of (0, 0)
module video_timing_gen #(
  parameter int WIDTH       = 1920,
  parameter int HEIGHT      = 1080,
  parameter int H_SYNC_TIME = 44,
  parameter int H_B_PORCH   = 148,
  parameter int H_F_PORCH   = 88,
  parameter int V_SYNC_TIME = 5,
  parameter int V_B_PORCH   = 36,
  parameter int V_F_PORCH   = 4,
  parameter bit HS_POL      = 1'b1,
  parameter bit VS_POL      = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] x,
  output logic [15:0] y,
  output logic        vde,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start
);

  localparam int H_TOTAL = H_SYNC_TIME + H_B_PORCH + WIDTH + H_F_PORCH;
  localparam int V_TOTAL = V_SYNC_TIME + V_B_PORCH + HEIGHT + V_F_PORCH;

  // Totals are computed in 32 bits so an oversized raster is caught here
  // instead of being truncated into the 16-bit counters.
  if (WIDTH < 1 || HEIGHT < 1 || H_SYNC_TIME < 1 || H_B_PORCH < 1 || H_F_PORCH < 1 ||
      V_SYNC_TIME < 1 || V_B_PORCH < 1 || V_F_PORCH < 1) begin : gBadParam
    $error("video_timing_gen: every timing parameter must be at least 1");
  end
  if (H_TOTAL >= 65536 || V_TOTAL >= 65536) begin : gBadTotal
    $error("video_timing_gen: H_TOTAL and V_TOTAL must each be below 65536");
  end

  // Last count of each region; a state leaves its region on the edge where
  // the counter sits on that count.
  localparam logic [15:0] H_SYNC_LAST = 16'(H_SYNC_TIME - 1);
  localparam logic [15:0] H_BP_LAST   = 16'(H_SYNC_TIME + H_B_PORCH - 1);
  localparam logic [15:0] H_ACT_LAST  = 16'(H_SYNC_TIME + H_B_PORCH + WIDTH - 1);
  localparam logic [15:0] H_LAST      = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_SYNC_LAST = 16'(V_SYNC_TIME - 1);
  localparam logic [15:0] V_BP_LAST   = 16'(V_SYNC_TIME + V_B_PORCH - 1);
  localparam logic [15:0] V_ACT_LAST  = 16'(V_SYNC_TIME + V_B_PORCH + HEIGHT - 1);
  localparam logic [15:0] V_LAST      = 16'(V_TOTAL - 1);

  typedef enum logic [1:0] {SYNC, BPORCH, ACTIVE, FPORCH} axisState_e;

  axisState_e  hState, hStateNext, vState, vStateNext;
  logic [15:0] hc, hcNext, vc, vcNext;
  logic        hWrap, vWrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc     <= '0;
      vc     <= '0;
      hState <= SYNC;
      vState <= SYNC;
    end else begin
      hc     <= hcNext;
      vc     <= vcNext;
      hState <= hStateNext;
      vState <= vStateNext;
    end
  end

  always_comb begin
    hWrap      = (hc == H_LAST);
    vWrap      = (vc == V_LAST);
    hcNext     = hc;
    vcNext     = vc;
    hStateNext = hState;
    vStateNext = vState;
    if (en) begin
      hcNext = hWrap ? 16'd0 : hc + 16'd1;
      case (hState)
        SYNC:    if (hc == H_SYNC_LAST) hStateNext = BPORCH;
        BPORCH:  if (hc == H_BP_LAST)   hStateNext = ACTIVE;
        ACTIVE:  if (hc == H_ACT_LAST)  hStateNext = FPORCH;
        FPORCH:  if (hWrap)             hStateNext = SYNC;
        default:                        hStateNext = SYNC;
      endcase
      // The vertical axis only moves on the last pixel of a line.
      if (hWrap) begin
        vcNext = vWrap ? 16'd0 : vc + 16'd1;
        case (vState)
          SYNC:    if (vc == V_SYNC_LAST) vStateNext = BPORCH;
          BPORCH:  if (vc == V_BP_LAST)   vStateNext = ACTIVE;
          ACTIVE:  if (vc == V_ACT_LAST)  vStateNext = FPORCH;
          FPORCH:  if (vWrap)             vStateNext = SYNC;
          default:                        vStateNext = SYNC;
        endcase
      end
    end
  end

  // Output stage presents the position the counters held before this edge,
  // so the outputs trail the counters by exactly one enabled cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x           <= '0;
      y           <= '0;
      vde         <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      x           <= hc;
      y           <= vc;
      vde         <= (hState == ACTIVE) && (vState == ACTIVE);
      hsync       <= (hState == SYNC) ? HS_POL : ~HS_POL;
      vsync       <= (vState == SYNC) ? VS_POL : ~VS_POL;
      line_start  <= (hc == 16'd0);
      frame_start <= (hc == 16'd0) && (vc == 16'd0);
    end else begin
      // Held position must not look like a fresh line or frame start.
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - scoreboard bench for video_timing_gen on two small rasters
module tb_video_timing_gen;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        vde;
    logic        hsync;
    logic        vsync;
    logic        ls;
    logic        fs;
  } outT;

  // Instance 0: 4x2 active, all porches/syncs 1, active-low syncs (7 x 5 raster).
  // Instance 1: 6x3 active, asymmetric porches, active-high syncs (13 x 8 raster).
  localparam int P_W   [2] = '{4, 6};
  localparam int P_H   [2] = '{2, 3};
  localparam int P_HS  [2] = '{1, 2};
  localparam int P_HBP [2] = '{1, 3};
  localparam int P_HFP [2] = '{1, 2};
  localparam int P_VS  [2] = '{1, 2};
  localparam int P_VBP [2] = '{1, 2};
  localparam int P_VFP [2] = '{1, 1};
  localparam bit P_POL [2] = '{1'b0, 1'b1};

  // Hand-computed: frame period, vde cycles per frame, sync-active cycles per line.
  localparam int FRAME [2] = '{35, 104};
  localparam int VDEF  [2] = '{8, 18};
  localparam int HSL   [2] = '{1, 2};

  logic clk = 1'b0;
  logic rst;
  logic en;
  always #5 clk = ~clk;

  logic [15:0] xA, yA, xB, yB;
  logic vdeA, hsA, vsA, lsA, fsA, vdeB, hsB, vsB, lsB, fsB;
  outT actA, actB;
  assign actA = {xA, yA, vdeA, hsA, vsA, lsA, fsA};
  assign actB = {xB, yB, vdeB, hsB, vsB, lsB, fsB};

  video_timing_gen #(
    .WIDTH(4), .HEIGHT(2), .H_SYNC_TIME(1), .H_B_PORCH(1), .H_F_PORCH(1),
    .V_SYNC_TIME(1), .V_B_PORCH(1), .V_F_PORCH(1), .HS_POL(1'b0), .VS_POL(1'b0)
  ) dutA (
    .clk(clk), .rst(rst), .en(en), .x(xA), .y(yA), .vde(vdeA), .hsync(hsA),
    .vsync(vsA), .line_start(lsA), .frame_start(fsA)
  );

  video_timing_gen #(
    .WIDTH(6), .HEIGHT(3), .H_SYNC_TIME(2), .H_B_PORCH(3), .H_F_PORCH(2),
    .V_SYNC_TIME(2), .V_B_PORCH(2), .V_F_PORCH(1), .HS_POL(1'b1), .VS_POL(1'b1)
  ) dutB (
    .clk(clk), .rst(rst), .en(en), .x(xB), .y(yB), .vde(vdeB), .hsync(hsB),
    .vsync(vsB), .line_start(lsB), .frame_start(fsB)
  );

  int  nChecks = 0;
  int  nPass   = 0;
  outT expQ0[$];
  outT expQ1[$];
  int  mx[2], my[2];
  outT mo[2];
  logic monOn   = 1'b0;
  logic measure = 1'b0;

  function automatic int hTot(input int i);
    return P_HS[i] + P_HBP[i] + P_W[i] + P_HFP[i];
  endfunction

  function automatic int vTot(input int i);
    return P_VS[i] + P_VBP[i] + P_H[i] + P_VFP[i];
  endfunction

  function automatic outT mk(input int px, input int py, input logic v, input logic h,
                             input logic vs, input logic l, input logic f);
    outT o;
    o.x = 16'(px); o.y = 16'(py); o.vde = v; o.hsync = h; o.vsync = vs; o.ls = l; o.fs = f;
    return o;
  endfunction

  function automatic outT rstVal(input int i);
    return mk(0, 0, 1'b0, ~P_POL[i], ~P_POL[i], 1'b0, 1'b0);
  endfunction

  // Position-based decode of what a given raster position should look like.
  function automatic outT decode(input int i, input int px, input int py);
    int ha, va;
    logic inH, inV;
    ha  = P_HS[i] + P_HBP[i];
    va  = P_VS[i] + P_VBP[i];
    inH = (px >= ha) && (px < ha + P_W[i]);
    inV = (py >= va) && (py < va + P_H[i]);
    return mk(px, py, inH && inV,
              (px < P_HS[i]) ? P_POL[i] : ~P_POL[i],
              (py < P_VS[i]) ? P_POL[i] : ~P_POL[i],
              px == 0, (px == 0) && (py == 0));
  endfunction

  task automatic push(input int i, input outT o);
    if (i == 0) expQ0.push_back(o);
    else        expQ1.push_back(o);
  endtask

  // Expected outputs after the coming clock edge for the given inputs.
  task automatic predictEdge(input logic e, input logic r);
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        mx[i] = 0; my[i] = 0; mo[i] = rstVal(i);
      end else if (e) begin
        mo[i] = decode(i, mx[i], my[i]);
        if (mx[i] == hTot(i) - 1) begin
          mx[i] = 0;
          my[i] = (my[i] == vTot(i) - 1) ? 0 : my[i] + 1;
        end else begin
          mx[i] = mx[i] + 1;
        end
      end else begin
        mo[i].ls = 1'b0;
        mo[i].fs = 1'b0;
      end
      push(i, mo[i]);
    end
  endtask

  // Called at a negedge: drive inputs, predict the next edge, wait for the next negedge.
  task automatic cycle(input logic e, input logic r);
    rst = r;
    en  = e;
    predictEdge(e, r);
    @(negedge clk);
  endtask

  task automatic cmpInt(input string name, input int i, input int act, input int exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("FAIL %s inst%0d: got %0d, expected %0d", name, i, act, exp);
  endtask

  task automatic cmpOut(input string name, input int i, input outT act, input outT exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s inst%0d: got x=%0d y=%0d vde=%b hs=%b vs=%b ls=%b fs=%b, expected x=%0d y=%0d vde=%b hs=%b vs=%b ls=%b fs=%b",
                  name, i, act.x, act.y, act.vde, act.hsync, act.vsync, act.ls, act.fs,
                  exp.x, exp.y, exp.vde, exp.hsync, exp.vsync, exp.ls, exp.fs);
  endtask

  // Asserted at a negedge so the async response is visible before any clock edge.
  task automatic assertRst(input logic e);
    rst = 1'b1;
    en  = e;
    for (int i = 0; i < 2; i++) begin
      mx[i] = 0; my[i] = 0; mo[i] = rstVal(i);
      push(i, mo[i]);
    end
    #1;
    cmpOut("async_reset", 0, actA, mk(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    cmpOut("async_reset", 1, actB, mk(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    predictEdge(e, 1'b1);
    @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  int   gap[2], vdeCnt[2], hsCnt[2];
  logic seenFs[2], seenLs[2];

  task automatic popCheck(input int i, input outT act);
    outT exp;
    if ((i == 0 ? expQ0.size() : expQ1.size()) == 0) begin
      nChecks++;
      $display("FAIL scoreboard_underflow inst%0d: got empty queue, expected an entry", i);
      return;
    end
    exp = (i == 0) ? expQ0.pop_front() : expQ1.pop_front();
    cmpOut("outputs", i, act, exp);
  endtask

  task automatic measureSample(input int i, input outT o);
    if (!measure) begin
      seenFs[i] = 1'b0; seenLs[i] = 1'b0;
      return;
    end
    gap[i]++;
    if (o.fs) begin
      if (seenFs[i]) begin
        cmpInt("frame_period", i, gap[i], FRAME[i]);
        cmpInt("vde_per_frame", i, vdeCnt[i], VDEF[i]);
      end
      seenFs[i] = 1'b1; gap[i] = 0; vdeCnt[i] = 0;
    end
    if (o.ls) begin
      if (seenLs[i]) cmpInt("hsync_per_line", i, hsCnt[i], HSL[i]);
      seenLs[i] = 1'b1; hsCnt[i] = 0;
    end
    vdeCnt[i] += int'(o.vde);
    hsCnt[i]  += int'(o.hsync == P_POL[i]);
  endtask

  initial begin
    wait (monOn);
    forever begin
      @(posedge clk or posedge rst);
      #1;
      popCheck(0, actA);
      popCheck(1, actB);
      measureSample(0, actA);
      measureSample(1, actB);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    en  = 1'b0;
    @(negedge clk);
    monOn = 1'b1;
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1);

    // Clean run: first released edge presents (0,0) with both strobes.
    measure = 1'b1;
    cycle(1'b1, 1'b0);
    cmpOut("first_edge", 0, actA, mk(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    cmpOut("first_edge", 1, actB, mk(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
    for (int k = 0; k < 320; k++) cycle(1'b1, 1'b0);
    measure = 1'b0;

    // Enable hold on the last raster position of instance 0.
    for (int k = 0; k < 100 && !(mo[0].x == 16'd6 && mo[0].y == 16'd4); k++) cycle(1'b1, 1'b0);
    for (int k = 0; k < 7; k++) cycle(1'b0, 1'b0);
    cmpOut("hold_last_pos", 0, actA, mk(6, 4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    cycle(1'b1, 1'b0);
    cmpOut("resume_wrap", 0, actA, mk(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));

    // Mid-frame reset while instance 0 shows an active pixel.
    for (int k = 0; k < 100 && !(mo[0].x == 16'd3 && mo[0].y == 16'd2); k++) cycle(1'b1, 1'b0);
    cmpOut("pre_reset_active", 0, actA, mk(3, 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    assertRst(1'b1);
    cycle(1'b1, 1'b0);
    cmpOut("restart_after_reset", 0, actA, mk(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    for (int k = 0; k < 20; k++) cycle(1'b1, 1'b0);

    // Reset with en low, then stay disabled before resuming.
    assertRst(1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    cmpOut("restart_after_idle", 1, actB, mk(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
    for (int k = 0; k < 120; k++) cycle(1'b1, 1'b0);

    #3;
    cmpInt("queue_drained", 0, expQ0.size(), 0);
    cmpInt("queue_drained", 1, expQ1.size(), 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected stimulus to finish");
    $fatal(1, "watchdog");
  end

endmodule
